avalon_s_arbiter: RTL

- Round-robin arbiter that lets NH Avalon-standard hosts share one Avalon-standard host port.
- Its device-side port drives the host-side inputs of the address decoder/router, so several CPUs/DMAs reach the same device set.
- Adds zero cycles to an unstalled transfer.
- Holds the grant while the downstream port stalls, and routes fixed-latency-1 read data back to the host that issued the read.

---
 rtl/avalon_s_pkg.sv | 39 +++
 rtl/avalon_s_rr_pick.sv | 28 ++
 rtl/avalon_s_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/avalon_s_pkg.sv
// Shared types and helpers for the Avalon round-robin arbiter.
// The optional bus-lock feature is enabled by defining AVALON_ARB_LOCK_EN.
package avalon_s_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Width of a host index; at least one bit so a single-bit pointer is legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot grant: first set bit of req found searching upward from ptr,
  // wrapping at nh (nh need not be a power of two). Supports up to 16 hosts.
  function automatic logic [15:0] rr_pick(input logic [15:0] req,
                                          input logic [3:0]  ptr,
                                          input int          nh);
    logic [15:0] gnt;
    logic [4:0]  j;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < nh) begin
        j = {1'b0, ptr} + 5'(k);
        if (j >= 5'(nh)) j = j - 5'(nh);
        if (!found && req[j[3:0]]) begin
          gnt[j[3:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/avalon_s_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus encoded index.
// Reusable by any arbiter with up to 16 requesters.
module avalon_s_rr_pick
  import avalon_s_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [15:0] gnt16;

  // Priority search from ptr, then encode the winning position.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx   = '0;
    gnt16 = rr_pick(16'(req), 4'(ptr), N);
    for (int i = 0; i < 16; i++) begin
      if (gnt16[i]) idx = IW'(i);
    end
    gnt = gnt16[N-1:0];
  end

endmodule

// File: rtl/avalon_s_arbiter.sv
// Round-robin arbiter sharing one Avalon host port among NH hosts.
// Zero added latency when unstalled; grant held while the device stalls;
// latency-1 read data steered back to the issuing host.
// Optional bus lock for atomic RMW: define AVALON_ARB_LOCK_EN.
module avalon_s_arbiter
  import avalon_s_pkg::*;
#(
  parameter int NH = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NH-1:0]          hosts_avn_read,
  input  logic [NH-1:0]          hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]  hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0] hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]  hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]  hosts_avn_readdata,
  output logic [NH-1:0]          hosts_avn_waitrequest,
  output logic                   dev_avn_read,
  output logic                   dev_avn_write,
  output logic [AW-1:0]          dev_avn_address,
  output logic [DW/8-1:0]        dev_avn_byte_enable,
  output logic [DW-1:0]          dev_avn_writedata,
  input  logic [DW-1:0]          dev_avn_readdata,
  input  logic                   dev_avn_waitrequest,
`ifdef AVALON_ARB_LOCK_EN
  input  logic [NH-1:0]          hosts_avn_lock,
`endif
  output logic [NH-1:0]          grant
);

  localparam int HIW = idx_width(NH);

  arb_state_e     state_q, state_d;
  logic [NH-1:0]  grant_q, grant_d;
  logic [HIW-1:0] own_idx_q, own_idx_d;
  logic [HIW-1:0] rr_ptr_q, rr_ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [HIW-1:0] rsp_idx_q, rsp_idx_d;

  logic [NH-1:0]  req;
  logic [NH-1:0]  pick_gnt;
  logic [HIW-1:0] pick_idx;
  logic [HIW-1:0] cur_idx;
  logic [HIW-1:0] rr_next;
  logic           has_grant;
  logic           dev_active;
  logic           acc;
  logic           own_lock;

  assign req = hosts_avn_read | hosts_avn_write;

  avalon_s_rr_pick #(.N(NH), .IW(HIW)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Current owner: live pick when idle, registered owner otherwise.
  // Gated by rst_n so a transfer is dropped the instant reset asserts.
  always_comb begin
    grant   = '0;
    cur_idx = own_idx_q;
    if (state_q == IDLE) cur_idx = pick_idx;
    if (rst_n) grant = (state_q == IDLE) ? pick_gnt : grant_q;
    has_grant = |grant;
    rr_next   = (cur_idx == HIW'(NH - 1)) ? '0 : cur_idx + HIW'(1);
  end

  // Device-side mux: fields of the granted host, all zero without a grant.
  always_comb begin
    dev_avn_read        = 1'b0;
    dev_avn_write       = 1'b0;
    dev_avn_address     = '0;
    dev_avn_byte_enable = '0;
    dev_avn_writedata   = '0;
    if (has_grant) begin
      dev_avn_read        = hosts_avn_read[cur_idx];
      dev_avn_write       = hosts_avn_write[cur_idx];
      dev_avn_address     = hosts_avn_address[cur_idx];
      dev_avn_byte_enable = hosts_avn_byte_enable[cur_idx];
      dev_avn_writedata   = hosts_avn_writedata[cur_idx];
    end
  end

  assign dev_active = dev_avn_read | dev_avn_write;
  assign acc        = dev_active & ~dev_avn_waitrequest;

`ifdef AVALON_ARB_LOCK_EN
  assign own_lock = has_grant & hosts_avn_lock[cur_idx];
`else
  assign own_lock = 1'b0;
`endif

  assign hosts_avn_waitrequest = ~(grant & {NH{~dev_avn_waitrequest}});

  // Read data goes only to the host whose read was accepted last cycle.
  always_comb begin
    for (int i = 0; i < NH; i++) begin
      hosts_avn_readdata[i] = (rsp_valid_q && rsp_idx_q == HIW'(i)) ? dev_avn_readdata : '0;
    end
  end

  // Next-state logic: ownership, round-robin pointer and read-return tag.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    own_idx_d   = own_idx_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = acc & dev_avn_read;
    rsp_idx_d   = (acc & dev_avn_read) ? cur_idx : rsp_idx_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (own_lock) begin
            state_d   = LOCKED;
            grant_d   = grant;
            own_idx_d = cur_idx;
          end else begin
            rr_ptr_d = rr_next;
          end
        end else if (has_grant && dev_avn_waitrequest) begin
          state_d   = BUSY;
          grant_d   = grant;
          own_idx_d = cur_idx;
        end
      end
      BUSY: begin
        if (acc) begin
          if (own_lock) begin
            state_d = LOCKED;
          end else begin
            state_d  = IDLE;
            rr_ptr_d = rr_next;
          end
        end else if (!dev_active) begin
          // Owner withdrew its request mid-stall: release rather than hang.
          state_d = IDLE;
        end
      end
`ifdef AVALON_ARB_LOCK_EN
      LOCKED: begin
        if ((acc && !own_lock) || (!dev_active && !own_lock)) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      own_idx_q   <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      own_idx_q   <= own_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

endmodule
